// File: rtl/serial_sum_collector.sv
// rtl/serial_sum_collector.sv - bit-serial sum collector with parallel valid/ready result
//
// Purpose:
//   Collects WIDTH serial sum bits (LSB first) from an upstream bit-serial adder.
//   It also captures the adder carry alongside the last bit.
//   It then presents {carry, sum} as one word behind a valid/ready handshake.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-low reset
//   start      in   1      frame start pulse; s_in in the following cycle is bit 0
//   s_in       in   1      serial sum bit
//   c_in       in   1      adder carry, sampled only with bit WIDTH-1
//   out_ready  in   1      consumer accepts the held result
//   sum        out  WIDTH  collected sum word (bit k = k-th serial bit)
//   carry      out  1      final carry of the frame
//   out_valid  out  1      sum/carry hold a complete, unconsumed result
//   busy       out  1      collecting a frame
//   frame_err  out  1      one-cycle pulse: start seen while collecting

module serial_sum_collector #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_in,
  input  logic             c_in,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid,
  output logic             busy,
  output logic             frame_err
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_HOLD
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-2:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_frame_err;

  logic [WIDTH-1:0] w_shift_next;
  logic             w_last;
  logic             w_load;

  // New bit enters at the MSB; after WIDTH samples, bit 0 has reached the LSB.
  // The shift register keeps only WIDTH-1 bits because the newest bit is s_in itself.
  assign w_shift_next = {s_in, r_shift};
  assign w_last       = (r_state == ST_COLLECT) && (r_cnt == LAST);
  // A frame starts from IDLE, or straight out of HOLD when the result is consumed in the same cycle.
  assign w_load       = start && ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (w_last) begin
          w_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_next = start ? ST_COLLECT : ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift     <= '0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_out_valid <= (w_next == ST_HOLD);
      r_busy      <= (w_next == ST_COLLECT);
      // Start during COLLECT is flagged but otherwise ignored.
      r_frame_err <= (r_state == ST_COLLECT) && start;
      if (w_load) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end else if (r_state == ST_COLLECT) begin
        r_shift <= w_shift_next[WIDTH-1:1];
        if (w_last) begin
          r_cnt   <= '0;
          r_sum   <= w_shift_next;
          r_carry <= c_in;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign sum       = r_sum;
  assign carry     = r_carry;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_serial_sum_collector.sv
// tb/tb_serial_sum_collector.sv - directed self-checking bench for serial_sum_collector

module tb_serial_sum_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       s_in;
  logic       c_in;
  logic       out_ready;
  logic [7:0] sum;
  logic       carry;
  logic       out_valid;
  logic       busy;
  logic       frame_err;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_sum;
  logic       exp_carry;

  serial_sum_collector #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .s_in      (s_in),
    .c_in      (c_in),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .out_valid (out_valid),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks the full output vector {sum, carry, out_valid, busy, frame_err}.
  task automatic chk_all(input string tag, input logic [7:0] s, input logic c,
                         input logic v, input logic b, input logic e);
    chk(tag, {20'd0, sum, carry, out_valid, busy, frame_err}, {20'd0, s, c, v, b, e});
  endtask

  task automatic begin_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("begin_busy", {31'd0, busy}, 32'd1);
  endtask

  // Streams 8 bits LSB first; c_in is driven to ~c on all but the last bit,
  // so only the last-bit sample can produce the expected carry.
  task automatic collect_bits(input logic [7:0] d, input logic c, input int spur);
    for (int i = 0; i < 8; i++) begin
      s_in  = d[i];
      c_in  = (i == 7) ? c : ~c;
      start = (i == spur);
      step();
      start = 1'b0;
      if (i < 7) begin
        chk_all("collect", exp_sum, exp_carry, 1'b0, 1'b1, (i == spur));
      end else begin
        exp_sum   = d;
        exp_carry = c;
        chk_all("result", exp_sum, exp_carry, 1'b1, 1'b0, 1'b0);
      end
    end
    s_in = 1'b0;
    c_in = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_all("consume", exp_sum, exp_carry, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    s_in      = 1'b0;
    c_in      = 1'b0;
    out_ready = 1'b0;
    exp_sum   = 8'h00;
    exp_carry = 1'b0;

    // 1. reset, then idle
    step();
    step();
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all("idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // 2. basic frame 0x65, carry 1, held under backpressure
    begin_frame();
    collect_bits(8'h65, 1'b1, -1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all("hold", 8'h65, 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // 3. back-to-back: consume and start together, then 0xFF with carry 0
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    out_ready = 1'b0;
    start     = 1'b0;
    chk_all("b2b_restart", 8'h65, 1'b1, 1'b0, 1'b1, 1'b0);
    collect_bits(8'hFF, 1'b0, -1);
    consume();

    // 4. spurious start at bit 3 of frame 0xA5
    begin_frame();
    collect_bits(8'hA5, 1'b1, 3);
    consume();

    // 5. reset mid-frame, then a fresh 0x3C frame
    begin_frame();
    collect_bits_partial: for (int i = 0; i < 4; i++) begin
      s_in = 1'b1;
      step();
    end
    rst = 1'b0;
    #1;
    chk_all("async_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_sum   = 8'h00;
    exp_carry = 1'b0;
    step();
    rst  = 1'b1;
    s_in = 1'b0;
    step();
    chk_all("post_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    begin_frame();
    collect_bits(8'h3C, 1'b0, -1);

    // 6. backpressure with start pulsed in HOLD
    start = 1'b1;
    step();
    start = 1'b0;
    chk_all("hold_start_ignored", 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("hold_stable", 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_all("ready_when_idle", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
